// File: rtl/divsub_seq.sv
// Sequential restoring divider: 20-bit dividend by 8-bit divisor, one quotient bit per clock,
// with optional two's-complement mode and fixed 22-cycle start-to-done latency.
module divsub_seq #(
   parameter int NoConfigBits = 1
) (
   input  logic                    UserCLK,
   input  logic                    clr_n,
   input  logic [19:0]             N,
   input  logic [7:0]              D,
   input  logic                    start,
   output logic [19:0]             Q,
   output logic [7:0]              R,
   output logic                    busy,
   output logic                    done,
   output logic                    div0,
   output logic                    ovf,
   input  logic [NoConfigBits-1:0] ConfigBits
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]  r_state;
   logic [19:0] r_n;
   logic [7:0]  r_d;
   logic        r_mode;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [19:0] r_quo;
   logic [7:0]  r_dm;
   logic [7:0]  r_rem;
   logic [4:0]  r_cnt;

   logic [8:0]  w_shift;
   logic [9:0]  w_diff;
   logic        w_ge;
   logic        w_div0;
   logic        w_ovf;

   // r_quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in
   assign w_shift = {r_rem, r_quo[19]};
   assign w_diff  = {1'b0, w_shift} - {2'b00, r_dm};
   assign w_ge    = ~w_diff[9];
   assign w_div0  = (r_d == 8'h00);
   assign w_ovf   = r_mode && (r_n == 20'h80000) && (r_d == 8'hFF);

   always_ff @(posedge UserCLK or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= S_IDLE;
         r_n     <= '0;
         r_d     <= '0;
         r_mode  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_quo   <= '0;
         r_dm    <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         Q       <= '0;
         R       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         div0    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_n     <= N;
                  r_d     <= D;
                  r_mode  <= ConfigBits[0];
                  busy    <= 1'b1;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Magnitudes fit unsigned: |N| <= 2^19, |D| <= 128
               r_quo   <= (r_mode && r_n[19]) ? -r_n : r_n;
               r_dm    <= (r_mode && r_d[7])  ? -r_d : r_d;
               r_neg_q <= r_mode & (r_n[19] ^ r_d[7]);
               r_neg_r <= r_mode & r_n[19];
               r_rem   <= '0;
               r_cnt   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_rem   <= w_ge ? w_diff[7:0] : w_shift[7:0];
               r_quo   <= {r_quo[18:0], w_ge};
               r_cnt   <= r_cnt + 5'd1;
               if (r_cnt == 5'd19)
                  r_state <= S_FIX;
            end
            S_FIX: begin
               if (w_div0) begin
                  Q <= 20'hFFFFF;
                  R <= r_n[7:0];
               end else if (w_ovf) begin
                  Q <= 20'h80000;
                  R <= 8'h00;
               end else begin
                  Q <= r_neg_q ? -r_quo : r_quo;
                  R <= r_neg_r ? -r_rem : r_rem;
               end
               div0    <= w_div0;
               ovf     <= w_ovf & ~w_div0;
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divsub_seq.sv
// Directed bench for divsub_seq: arithmetic reference model with a per-cycle compare,
// plus literal expectations for each directed division.
module tb_divsub_seq;

   logic        UserCLK;
   logic        clr_n;
   logic [19:0] N;
   logic [7:0]  D;
   logic        start;
   logic [19:0] Q;
   logic [7:0]  R;
   logic        busy, done, div0, ovf;
   logic [0:0]  ConfigBits;

   int tests = 0;
   int fails = 0;

   divsub_seq #(.NoConfigBits(1)) dut (
      .UserCLK(UserCLK), .clr_n(clr_n), .N(N), .D(D), .start(start),
      .Q(Q), .R(R), .busy(busy), .done(done), .div0(div0), .ovf(ovf),
      .ConfigBits(ConfigBits)
   );

   initial begin
      UserCLK = 1'b0;
      forever #5 UserCLK = ~UserCLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference arithmetic straight from the division rules
   function automatic void model(input logic [19:0] n, input logic [7:0] d, input logic m,
                                 output logic [19:0] q, output logic [7:0] r,
                                 output logic z, output logic o);
      int sn, sd, iq, ir;
      z = 1'b0;
      o = 1'b0;
      if (d == 8'h00) begin
         q = 20'hFFFFF;
         r = n[7:0];
         z = 1'b1;
      end else if (m && n == 20'h80000 && d == 8'hFF) begin
         q = 20'h80000;
         r = 8'h00;
         o = 1'b1;
      end else if (m) begin
         sn = {{12{n[19]}}, n};
         sd = {{24{d[7]}}, d};
         iq = sn / sd;
         ir = sn % sd;
         q  = iq[19:0];
         r  = ir[7:0];
      end else begin
         q = n / {12'd0, d};
         r = 8'(n % {12'd0, d});
      end
   endfunction

   // Timing model: an accepted start produces done 22 edges later; start ignored while busy
   int          cyc;
   int          m_at;
   logic        m_busy, m_done, m_z, m_o, p_z, p_o;
   logic [19:0] m_q, p_q;
   logic [7:0]  m_r, p_r;

   always @(posedge UserCLK or negedge clr_n) begin
      if (!clr_n) begin
         cyc = 0; m_at = 0;
         m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_z = 0; m_o = 0;
      end else begin
         cyc++;
         m_done = 0;
         if (m_busy && cyc == m_at) begin
            m_busy = 0; m_done = 1;
            m_q = p_q; m_r = p_r; m_z = p_z; m_o = p_o;
         end else if (!m_busy && start) begin
            m_busy = 1;
            m_at   = cyc + 22;
            model(N, D, ConfigBits[0], p_q, p_r, p_z, p_o);
         end
      end
   end

   always @(negedge UserCLK) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc Q",    Q,    m_q);
      chk("cyc R",    R,    m_r);
      chk("cyc div0", div0, m_z);
      chk("cyc ovf",  ovf,  m_o);
   end

   task automatic wait_done(input string nm);
      int lat = 0;
      while (!done && lat < 40) begin
         @(negedge UserCLK);
         lat++;
      end
      chk({nm, " latency"}, lat, 22);
   endtask

   task automatic run(input string nm, input logic [19:0] n, input logic [7:0] d, input logic m,
                      input logic [19:0] eq, input logic [7:0] er, input logic ez, input logic eo);
      logic [19:0] mq;
      logic [7:0]  mr;
      logic        mz, mo;
      model(n, d, m, mq, mr, mz, mo);
      chk({nm, " model Q"}, mq, eq);
      chk({nm, " model R"}, mr, er);
      @(negedge UserCLK);
      N = n; D = d; ConfigBits = m; start = 1'b1;
      @(negedge UserCLK);
      start = 1'b0;
      ConfigBits = ~m;
      wait_done(nm);
      chk({nm, " Q"},    Q,    eq);
      chk({nm, " R"},    R,    er);
      chk({nm, " div0"}, div0, ez);
      chk({nm, " ovf"},  ovf,  eo);
   endtask

   initial begin
      int ndone;
      clr_n = 1'b0; start = 1'b0; N = '0; D = '0; ConfigBits = '0;
      repeat (3) @(negedge UserCLK);
      chk("reset Q", Q, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      #2 clr_n = 1'b1;

      run("u1000/7",    20'd1000,   8'd7,   1'b0, 20'd142,   8'd6,   1'b0, 1'b0);
      run("s-1000/7",   20'hFFC18,  8'd7,   1'b1, 20'hFFF72, 8'hFA,  1'b0, 1'b0);
      run("s1000/-7",   20'd1000,   8'hF9,  1'b1, 20'hFFF72, 8'h06,  1'b0, 1'b0);
      run("u div0",     20'h03039,  8'd0,   1'b0, 20'hFFFFF, 8'h39,  1'b1, 1'b0);
      run("s div0",     20'h03039,  8'd0,   1'b1, 20'hFFFFF, 8'h39,  1'b1, 1'b0);
      run("u255/255",   20'd255,    8'd255, 1'b0, 20'd1,     8'd0,   1'b0, 1'b0);
      run("s ovf",      20'h80000,  8'hFF,  1'b1, 20'h80000, 8'h00,  1'b0, 1'b1);
      run("u 80000/FF", 20'h80000,  8'hFF,  1'b0, 20'd2056,  8'd8,   1'b0, 1'b0);
      run("s-128",      20'hFFF80,  8'h80,  1'b1, 20'd1,     8'd0,   1'b0, 1'b0);

      // Starts during a division are dropped
      @(negedge UserCLK);
      N = 20'd1000; D = 8'd7; ConfigBits = 1'b0; start = 1'b1;
      @(negedge UserCLK);
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge UserCLK);
         if (i == 5 || i == 15) begin
            N = 20'h12345; D = 8'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge UserCLK);
         start = 1'b0;
         if (done) ndone++;
      end
      chk("ignore ndone", ndone, 1);
      chk("ignore Q", Q, 20'd142);
      chk("ignore R", R, 8'd6);

      // start held through the done cycle restarts immediately
      @(negedge UserCLK);
      N = 20'd500; D = 8'd9; ConfigBits = 1'b0; start = 1'b1;
      @(negedge UserCLK);
      wait_done("hold first");
      chk("hold first Q", Q, 20'd55);
      N = 20'd100; D = 8'd3;
      @(negedge UserCLK);
      start = 1'b0;
      chk("hold restart busy", busy, 1);
      wait_done("hold second");
      chk("hold second Q", Q, 20'd33);
      chk("hold second R", R, 8'd1);

      // Asynchronous abort mid-division
      @(negedge UserCLK);
      N = 20'd1000; D = 8'd7; ConfigBits = 1'b0; start = 1'b1;
      @(negedge UserCLK);
      start = 1'b0;
      repeat (10) @(negedge UserCLK);
      #2 clr_n = 1'b0;
      #1;
      chk("abort Q", Q, 0);
      chk("abort R", R, 0);
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      repeat (2) @(negedge UserCLK);
      #2 clr_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge UserCLK);
         if (done) ndone++;
      end
      chk("abort no done", ndone, 0);
      run("post-reset 1000/7", 20'd1000, 8'd7, 1'b0, 20'd142, 8'd6, 1'b0, 1'b0);

      repeat (2) @(negedge UserCLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
